// File: rtl/kos_sub_pipe_8.sv
`timescale 1ns/1ps
// kos_sub_pipe_8: pipelined 8-bit Kogge-Stone subtractor, d = a - b - bi (mod 256).
// Latency: two register stages (accepting edge loads stage 1, next edge loads the outputs).
// Backpressure: valid/ready at both ends; in_ready falls only when both stages hold
// data and out_ready is low. Stalled stages hold their contents unchanged.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, bi)
//   out_valid / out_ready result handshake (d, bo, ovf)
//   a, b                  minuend, subtrahend (unsigned or two's complement)
//   bi                    borrow in (1 = subtract one more)
//   d                     difference a - b - bi mod 256
//   bo                    borrow out (1 when a < b + bi, unsigned)
//   ovf                   signed overflow of the subtraction
//
// Build option: KOS_SUB_OVF_EN
//   defined   -> ovf is computed; a[7] and b[7] travel through stage 1.
//   undefined -> ovf is tied to 0 and the sign-bit registers do not exist.
//
// Subtraction is done as a + ~b + ~bi. The prefix network carries the
// carry-in as an extra least-significant position (index 0), so every
// generate/propagate vector below is indexed 8..0 with bit i of the sum
// living at index i+1.

module kos_sub_pipe_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       bo,
    output logic       ovf
);

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic w_adv1;   // stage-1 register may load this cycle
    logic w_adv2;   // output register may load this cycle
    logic r_s1_vld;
    logic r_out_vld;

    // The output stage frees up the same cycle the consumer takes a beat,
    // so in_ready has a combinational path from out_ready. This is what
    // lets the pipe sustain one beat per cycle with no bubbles.
    assign w_adv2   = !r_out_vld || out_ready;
    assign w_adv1   = !r_s1_vld || w_adv2;
    assign in_ready = w_adv1;

    // ------------------------------------------------------------------
    // Level 0: operand transform and bitwise generate/propagate
    // ------------------------------------------------------------------
    logic [7:0] w_bn;   // inverted subtrahend
    logic [8:0] w_g0;   // index 0 is the carry-in (~bi)
    logic [8:1] w_p0;   // the carry-in position never propagates

    assign w_bn = ~b;
    assign w_g0 = {a & w_bn, ~bi};
    assign w_p0 = a ^ w_bn;

    // ------------------------------------------------------------------
    // Stage 1 combinational: Kogge-Stone levels 1 (span 1) and 2 (span 2)
    // ------------------------------------------------------------------
    // Group propagates are only formed where a later level consumes them.
    // Any group reaching down to index 0 has propagate 0 by construction,
    // so those positions are simply not built.
    logic [8:0] w_g1;
    logic [8:2] w_p1;
    logic [8:0] w_g2;
    logic [8:4] w_p2;

    assign w_g1[0] = w_g0[0];
    for (genvar i = 1; i <= 8; i++) begin : g_lvl1_g
        assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
    end
    for (genvar i = 2; i <= 8; i++) begin : g_lvl1_p
        assign w_p1[i] = w_p0[i] & w_p0[i-1];
    end

    assign w_g2[1:0] = w_g1[1:0];
    for (genvar i = 2; i <= 8; i++) begin : g_lvl2_g
        assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
    end
    for (genvar i = 4; i <= 8; i++) begin : g_lvl2_p
        assign w_p2[i] = w_p1[i] & w_p1[i-2];
    end

    // ------------------------------------------------------------------
    // Stage-1 registers
    // ------------------------------------------------------------------
    logic [8:0] r_s1_g;    // level-2 group generate
    logic [8:4] r_s1_p;    // level-2 group propagate (nonzero positions)
    logic [8:1] r_s1_p0;   // level-0 propagate, needed for the sum bits
`ifdef KOS_SUB_OVF_EN
    logic       r_s1_a7;
    logic       r_s1_b7;
`endif

    // ------------------------------------------------------------------
    // Stage 2 combinational: level 3 (span 4), sum, borrow, overflow
    // ------------------------------------------------------------------
    logic [8:0] w_g3;
    logic       w_c8;
    logic [7:0] w_d;
    logic       w_bo;

    assign w_g3[3:0] = r_s1_g[3:0];
    for (genvar i = 4; i <= 8; i++) begin : g_lvl3_g
        assign w_g3[i] = r_s1_g[i] | (r_s1_p[i] & r_s1_g[i-4]);
    end

    // After three levels index 8 spans positions 8..1 only; fold in the
    // carry-in position to get the full carry out of bit 7.
    assign w_c8 = w_g3[8] | (r_s1_p[8] & r_s1_p[4] & r_s1_g[0]);

    // Sum bit k uses propagate at index k+1 and the carry into it at index k.
    assign w_d  = r_s1_p0 ^ w_g3[7:0];
    assign w_bo = ~w_c8;

`ifdef KOS_SUB_OVF_EN
    logic w_ovf;
    // Subtraction overflows only when operand signs differ and the result
    // sign disagrees with the minuend.
    assign w_ovf = (r_s1_a7 != r_s1_b7) && (w_d[7] != r_s1_a7);
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [7:0] r_d;
    logic       r_bo;
`ifdef KOS_SUB_OVF_EN
    logic       r_ovf;
`endif

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // Data registers load whenever their stage advances, even behind an
    // empty beat; only the valid flags carry meaning for empty slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_g    <= '0;
            r_s1_p    <= '0;
            r_s1_p0   <= '0;
`ifdef KOS_SUB_OVF_EN
            r_s1_a7   <= 1'b0;
            r_s1_b7   <= 1'b0;
            r_ovf     <= 1'b0;
`endif
            r_out_vld <= 1'b0;
            r_d       <= '0;
            r_bo      <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_vld <= in_valid;
                r_s1_g   <= w_g2;
                r_s1_p   <= w_p2;
                r_s1_p0  <= w_p0;
`ifdef KOS_SUB_OVF_EN
                r_s1_a7  <= a[7];
                r_s1_b7  <= b[7];
`endif
            end
            if (w_adv2) begin
                r_out_vld <= r_s1_vld;
                r_d       <= w_d;
                r_bo      <= w_bo;
`ifdef KOS_SUB_OVF_EN
                r_ovf     <= w_ovf;
`endif
            end
        end
    end

    assign out_valid = r_out_vld;
    assign d         = r_d;
    assign bo        = r_bo;
`ifdef KOS_SUB_OVF_EN
    assign ovf       = r_ovf;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_kos_sub_pipe_8.sv
`timescale 1ns/1ps
// tb_kos_sub_pipe_8: table vectors, hand-written handshake/reset sequences and a
// randomised stream, all checked through an expected-result queue that is
// filled on input acceptance and drained on output transfer.

module tb_kos_sub_pipe_8;

`ifdef KOS_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bo;
    logic       ovf;

    always #5 clk = ~clk;

    kos_sub_pipe_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       ovf;   // value with overflow detection enabled
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;
    int   run_len  = 0;
    int   max_run  = 0;
    bit   stall_prev = 1'b0;
    res_t stall_val;
    res_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent arithmetic reference: 9-bit difference and signed range test.
    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbi);
        logic [8:0] diff;
        int         sd;
        res_t       r;
        diff  = {1'b0, ma} - {1'b0, mb} - {8'b0, mbi};
        sd    = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
        r.d   = diff[7:0];
        r.bo  = diff[8];
        r.ovf = OVF_EN && (sd > 127 || sd < -128);
        return r;
    endfunction

    // Output monitor: scoreboard pop, stall stability, run length.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            run_len    = 0;
        end else begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (stall_prev) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_dat", {d, bo, ovf}, stall_val);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out: got d=0x%0h with nothing expected at %0t", d, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_d",   d,   mon_e.d);
                    chk("out_bo",  bo,  mon_e.bo);
                    chk("out_ovf", ovf, mon_e.ovf);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {d, bo, ovf};
        end
    end

    // Random consumer back-pressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Offer one beat; push its expectation at the cycle it is accepted.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tbi, input res_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        bi = tbi;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 at %0t", $time);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(e);
        end
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", sb_q.size(), 0);
    endtask

    // Single beat into an empty pipe: out_valid low after the accepting
    // edge, high after the next one.
    task automatic lat_beat(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbi);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        bi = tbi;
        @(negedge clk);
        chk({tag, "_in_rdy"}, in_ready, 1);
        sb_q.push_back(model(ta, tb, tbi));
        tick();
        idle();
        @(negedge clk);
        chk({tag, "_s1_only"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_out_vld"}, out_valid, 1);
        tick();
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        tbl[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6]  = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        tbl[10] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        tbl[11] = '{8'h3C, 8'hA5, 1'b1, 8'h96, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bi = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_out_vld", out_valid, 0);
        chk("rst_d",       d,         0);
        chk("rst_bo",      bo,        0);
        chk("rst_ovf",     ovf,       0);
        chk("rst_in_rdy",  in_ready,  1);
        tick();
        rst = 1'b0;

        // Latency on an empty pipe
        lat_beat("lat", 8'h05, 8'h03, 1'b0);
        wait_drain();

        // Table vectors streamed back to back with the consumer always ready
        max_run = 0;
        for (int i = 0; i < NV; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].bi,
                 '{tbl[i].d, tbl[i].bo, tbl[i].ovf & OVF_EN});
        end
        idle();
        wait_drain();
        chk("stream_run", max_run, NV);

        // Back-pressure: two accepts fill the pipe, then in_ready drops
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));
        send(8'hAB, 8'h0F, 1'b1, model(8'hAB, 8'h0F, 1'b1));
        in_valid = 1'b1;
        a = 8'h44;
        b = 8'h45;
        bi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_rdy",  in_ready,  0);
            chk("bp_out_vld", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", in_ready, 1);
        sb_q.push_back(model(8'h44, 8'h45, 1'b0));
        tick();
        idle();
        wait_drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(8'h10, 8'h01, 1'b0, model(8'h10, 8'h01, 1'b0));
        send(8'h20, 8'h02, 1'b0, model(8'h20, 8'h02, 1'b0));
        idle();
        @(negedge clk);
        chk("pre_rst_full", in_ready, 0);
        tick();
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_vld", out_valid, 0);
        chk("midrst_d",       d,         0);
        chk("midrst_in_rdy",  in_ready,  1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("midrst_no_ghost", out_valid, 0);
        end
        tick();
        lat_beat("post_rst", 8'hC3, 8'h3C, 1'b1);
        wait_drain();

        // Randomised operands, gaps and consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                tick();
            end
            send(ra, rb, rbi, model(ra, rb, rbi));
        end
        idle();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
